// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one unified memory between instruction fetch (port 0)
// and load/store (port 1); one request at a time, registered response with ack pulse.
module mem_arbiter #(
  parameter logic [31:0] MEM_START  = 32'h8002_0000,
  parameter int          MEM_DEPTH  = 262144,
  parameter int          RESET_PRIO = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic        rw0,
  input  logic        rw1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_rw,
  output logic        mem_enable,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

  // End bound computed in 33 bits so a window touching the top of the space cannot wrap.
  localparam logic [32:0] MEM_END = {1'b0, MEM_START} + ({1'b0, 32'(MEM_DEPTH)} << 2) - 33'd1;
  localparam logic        PTR_INIT = (RESET_PRIO != 0) ? 1'b1 : 1'b0;

  function automatic logic in_range(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, MEM_START}) && ({1'b0, a} <= MEM_END);
  endfunction

  state_t      state_r;
  logic        owner_r;
  logic        ptr_r;
  logic        sel_port_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;
  logic        sel_rw_s;

  // Pick the winning port and mux its request fields.
  always_comb begin
    sel_port_s = 1'b0;
    if (req0 && req1) begin
      sel_port_s = ptr_r;
    end else if (req1) begin
      sel_port_s = 1'b1;
    end else begin
      sel_port_s = 1'b0;
    end
    if (sel_port_s) begin
      sel_addr_s  = addr1;
      sel_wdata_s = wdata1;
      sel_rw_s    = rw1;
    end else begin
      sel_addr_s  = addr0;
      sel_wdata_s = wdata0;
      sel_rw_s    = rw0;
    end
  end

  // Arbitration FSM with registered memory-side and response outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      owner_r     <= 1'b0;
      ptr_r       <= PTR_INIT;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      err0        <= 1'b0;
      err1        <= 1'b0;
      rdata0      <= 32'h0;
      rdata1      <= 32'h0;
      mem_address <= 32'h0;
      mem_data_in <= 32'h0;
      mem_rw      <= 1'b1;
      mem_enable  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ack0       <= 1'b0;
          ack1       <= 1'b0;
          err0       <= 1'b0;
          err1       <= 1'b0;
          mem_enable <= 1'b0;
          if (req0 || req1) begin
            owner_r     <= sel_port_s;
            mem_address <= sel_addr_s;
            mem_data_in <= sel_wdata_s;
            mem_rw      <= sel_rw_s;
            mem_enable  <= in_range(sel_addr_s);
            // Only a contended grant hands priority to the loser.
            if (req0 && req1) begin
              ptr_r <= ~sel_port_s;
            end
            state_r <= GRANT;
          end
        end
        GRANT: begin
          // mem_enable doubles as the registered in-range flag here.
          mem_enable <= 1'b0;
          if (owner_r) begin
            ack1 <= 1'b1;
            err1 <= ~mem_enable;
            if (!mem_enable) begin
              rdata1 <= 32'h0;
            end else if (mem_rw) begin
              rdata1 <= mem_data_out;
            end
          end else begin
            ack0 <= 1'b1;
            err0 <= ~mem_enable;
            if (!mem_enable) begin
              rdata0 <= 32'h0;
            end else if (mem_rw) begin
              rdata0 <= mem_data_out;
            end
          end
          state_r <= ACK;
        end
        ACK: begin
          ack0    <= 1'b0;
          ack1    <= 1'b0;
          err0    <= 1'b0;
          err1    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          ack0       <= 1'b0;
          ack1       <= 1'b0;
          err0       <= 1'b0;
          err1       <= 1'b0;
          mem_enable <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus contention/reset sequences,
// responses checked through an expectation queue against a small behavioural memory.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] addr0 = 32'h0, addr1 = 32'h0;
  logic [31:0] wdata0 = 32'h0, wdata1 = 32'h0;
  logic        rw0 = 1'b1, rw1 = 1'b1;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_rw, mem_enable;

  mem_arbiter #(.MEM_START(32'h8002_0000), .MEM_DEPTH(262144), .RESET_PRIO(1)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .rw0(rw0), .rw1(rw1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_rw(mem_rw), .mem_enable(mem_enable), .mem_data_out(mem_data_out)
  );

  always #5 clock = ~clock;

  // Behavioural memory: combinational read, write on posedge when enabled.
  logic [31:0] bmem [0:1023];
  initial for (int i = 0; i < 1024; i++) bmem[i] = 32'h0;
  assign mem_data_out = bmem[mem_address[11:2]];
  always @(posedge clock) if (mem_enable && !mem_rw) bmem[mem_address[11:2]] <= mem_data_in;

  typedef struct {
    logic        port;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_en;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    ack_cyc[$];
  logic  ack_port[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor: every ack pops one expectation and is checked against it.
  always @(negedge clock) begin
    if (!reset && (ack0 || ack1)) begin
      resp_t e;
      ack_cyc.push_back(cyc);
      ack_port.push_back(ack1);
      chk("single_ack", {31'h0, ack0 & ack1}, 32'h0);
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 32'h1, 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("ack_port", {31'h0, ack1}, {31'h0, e.port});
        chk("rdata", e.port ? rdata1 : rdata0, e.rdata);
        chk("err", {31'h0, e.port ? err1 : err0}, {31'h0, e.err});
        chk("other_err", {31'h0, e.port ? err0 : err1}, 32'h0);
      end
    end
  end

  task automatic drive(input logic port, input logic req, input logic rw,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin req1 = req; rw1 = rw; addr1 = addr; wdata1 = wdata; end
    else      begin req0 = req; rw0 = rw; addr0 = addr; wdata0 = wdata; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clock);
    chk({tag, "_ack0"}, {31'h0, ack0}, 32'h0);
    chk({tag, "_ack1"}, {31'h0, ack1}, 32'h0);
    chk({tag, "_err"}, {30'h0, err1, err0}, 32'h0);
    chk({tag, "_rdata0"}, rdata0, 32'h0);
    chk({tag, "_rdata1"}, rdata1, 32'h0);
    chk({tag, "_mem_en"}, {31'h0, mem_enable}, 32'h0);
    chk({tag, "_mem_addr"}, mem_address, 32'h0);
    chk({tag, "_mem_din"}, mem_data_in, 32'h0);
    chk({tag, "_mem_rw"}, {31'h0, mem_rw}, 32'h1);
  endtask

  // One uncontended request: checks GRANT-cycle memory drive and ack latency.
  task automatic do_req(input vec_t v, input string tag);
    resp_t e;
    e.port = v.port; e.rdata = v.exp_rdata; e.err = v.exp_err;
    exp_q.push_back(e);
    drive(v.port, 1'b1, v.rw, v.addr, v.wdata);
    @(negedge clock);
    chk({tag, "_ack_early"}, {30'h0, ack1, ack0}, 32'h0);
    @(negedge clock);
    chk({tag, "_grant_en"}, {31'h0, mem_enable}, {31'h0, v.exp_en});
    if (v.exp_en) chk({tag, "_grant_rw"}, {31'h0, mem_rw}, {31'h0, v.rw});
    chk({tag, "_ack_grant"}, {30'h0, ack1, ack0}, 32'h0);
    @(negedge clock);
    chk({tag, "_ack_lat"}, {30'h0, ack1, ack0}, v.port ? 32'h2 : 32'h1);
    chk({tag, "_ack_en"}, {31'h0, mem_enable}, 32'h0);
    @(posedge clock);
    #1 drive(v.port, 1'b0, v.rw, v.addr, v.wdata);
  endtask

  vec_t vecs[11];
  int   t_ack0, t_ack1;
  logic got0, got1;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 32'h8002_0000, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 32'h8002_0000, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 32'h8011_FFFC, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 32'h8011_FFFE, 32'h0,         1'b1, 32'h1234_5678, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'h8001_FFFC, 32'h0,         1'b0, 32'h0000_0000, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 32'h8012_0000, 32'h0,         1'b0, 32'h0000_0000, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 32'h8012_0000, 32'h5555_AAAA, 1'b0, 32'h0000_0000, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0,         1'b0, 32'h0000_0000, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 32'h8002_0004, 32'hA5A5_0F0F, 1'b1, 32'h0000_0000, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 32'h8002_0004, 32'h0,         1'b1, 32'hA5A5_0F0F, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'h8002_0004, 32'h0,         1'b1, 32'hA5A5_0F0F, 1'b0};

    do_reset();
    check_reset_outputs("reset");
    @(posedge clock);
    #1;
    for (int i = 0; i < 11; i++) do_req(vecs[i], $sformatf("vec%0d", i));

    // Simultaneous requests right after reset: port 1 first, port 0 three cycles later.
    do_reset();
    exp_q.push_back('{1'b1, 32'hDEAD_BEEF, 1'b0});
    exp_q.push_back('{1'b0, 32'hA5A5_0F0F, 1'b0});
    drive(1'b1, 1'b1, 1'b1, 32'h8002_0000, 32'h0);
    drive(1'b0, 1'b1, 1'b1, 32'h8002_0004, 32'h0);
    got0 = 1'b0; got1 = 1'b0; t_ack0 = -1; t_ack1 = -1;
    for (int c = 0; c < 20 && !(got0 && got1); c++) begin
      @(negedge clock);
      if (ack1 && !got1) begin got1 = 1'b1; t_ack1 = c; end
      if (ack0 && !got0) begin got0 = 1'b1; t_ack0 = c; end
      @(posedge clock);
      #1;
      if (got1) req1 = 1'b0;
      if (got0) req0 = 1'b0;
    end
    chk("contend_ack1_lat", t_ack1, 32'd2);
    chk("contend_ack0_lat", t_ack0, 32'd5);

    // Continuous requests from both ports: grants alternate 1,0,1,0, three cycles apart.
    do_reset();
    ack_cyc.delete();
    ack_port.delete();
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back('{1'b1, 32'hDEAD_BEEF, 1'b0});
      exp_q.push_back('{1'b0, 32'hA5A5_0F0F, 1'b0});
    end
    drive(1'b1, 1'b1, 1'b1, 32'h8002_0000, 32'h0);
    drive(1'b0, 1'b1, 1'b1, 32'h8002_0004, 32'h0);
    repeat (12) @(negedge clock);
    @(posedge clock);
    #1 req0 = 1'b0;
    req1 = 1'b0;
    repeat (3) @(negedge clock);
    chk("rr_ack_count", ack_cyc.size(), 32'd4);
    for (int k = 0; k < 4 && k < ack_cyc.size(); k++) begin
      chk($sformatf("rr_port%0d", k), {31'h0, ack_port[k]}, (k % 2 == 0) ? 32'h1 : 32'h0);
      if (k > 0) chk($sformatf("rr_gap%0d", k), ack_cyc[k] - ack_cyc[k-1], 32'd3);
    end

    // Reset during GRANT of a read: aborted with no ack, then normal service.
    @(posedge clock);
    #1 drive(1'b0, 1'b1, 1'b1, 32'h8002_0000, 32'h0);
    @(posedge clock);
    #1 reset = 1'b1;
    req0 = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    check_reset_outputs("abort");
    repeat (3) @(negedge clock);
    chk("abort_no_ack", {30'h0, ack1, ack0}, 32'h0);
    @(posedge clock);
    #1 do_req(vecs[1], "post_abort");
    repeat (3) @(negedge clock);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
